// File: rtl/raster_scheduler.sv
// Raster lane scheduler: hands object tasks to N_RAST stripe rasterizers one at a time and
// funnels each lane's pixel writes through a capture slot onto one framebuffer write port.
package raster_scheduler_pkg;

    typedef struct packed {
        logic [7:0]  id;
        logic [11:0] x_min;
        logic [11:0] x_max;
        logic [11:0] y_min;
        logic [11:0] y_max;
        logic [7:0]  shade;
    } object_t;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic [23:0] color;
    } pixel_info_t;

endpackage

module raster_scheduler
    import raster_scheduler_pkg::*;
#(
    parameter int N_RAST = 4,
    parameter int CNT_W  = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  object_t                  task_in,
    input  logic                     task_valid,
    output logic                     task_ready,
    output object_t                  task_out,
    output logic                     next_task,
    input  logic [N_RAST-1:0]        lane_task_complete,
    input  pixel_info_t [N_RAST-1:0] lane_pixel,
    input  logic [N_RAST-1:0]        lane_write,
    output logic [N_RAST-1:0]        lane_written,
    output pixel_info_t              fb_pixel,
    output logic                     fb_valid,
    input  logic                     fb_ready,
    output logic [CNT_W-1:0]         tasks_done,
    output logic                     overflow
);

    localparam int IDX_W = (N_RAST > 1) ? $clog2(N_RAST) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, START, RUN} state_t;

    state_t            state;
    state_t            state_next;
    logic [N_RAST-1:0] seen_busy;
    logic [N_RAST-1:0] lane_write_q;
    logic [N_RAST-1:0] write_edge;
    logic [N_RAST-1:0] slot_full;
    logic [N_RAST-1:0] lanes_done;
    pixel_info_t       slot [N_RAST];
    logic [IDX_W-1:0]  rr;
    logic [IDX_W-1:0]  grant_idx;
    logic              grant_valid;
    logic              out_free;
    logic              run_exit;

    assign write_edge   = lane_write & ~lane_write_q;
    assign lanes_done   = seen_busy & lane_task_complete;
    assign lane_written = ~slot_full;
    assign out_free     = ~fb_valid | fb_ready;

    // A task is only retired once every pixel it produced has left the block.
    assign run_exit = (&lanes_done) && (slot_full == '0) && !fb_valid && (write_edge == '0);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_next = state;
        task_ready = 1'b0;
        next_task  = 1'b0;
        case (state)
            IDLE: begin
                if (task_valid) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                task_ready = 1'b1;
                state_next = START;
            end
            START: begin
                next_task  = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                if (run_exit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A lane must be seen busy during this task before its complete flag counts.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            task_out   <= '0;
            seen_busy  <= '0;
            tasks_done <= '0;
        end else begin
            if (state == LOAD) begin
                task_out <= task_in;
            end
            if (state == START) begin
                seen_busy <= '0;
            end else if (state == RUN) begin
                seen_busy <= seen_busy | ~lane_task_complete;
            end
            if ((state == RUN) && run_exit) begin
                tasks_done <= tasks_done + CNT_W'(1);
            end
        end
    end

    always_comb begin : arbiter
        logic [IDX_W:0] cand;
        cand        = '0;
        grant_valid = 1'b0;
        grant_idx   = rr;
        for (int k = 1; k <= N_RAST; k++) begin
            cand = {1'b0, rr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N_RAST)) begin
                cand = cand - (IDX_W+1)'(N_RAST);
            end
            if (!grant_valid && slot_full[cand[IDX_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lane_write_q <= '0;
            slot_full    <= '0;
            overflow     <= 1'b0;
            fb_valid     <= 1'b0;
            fb_pixel     <= '0;
            rr           <= IDX_W'(N_RAST - 1);
        end else begin
            lane_write_q <= lane_write;
            for (int i = 0; i < N_RAST; i++) begin
                if (write_edge[i] && slot_full[i]) begin
                    overflow <= 1'b1;
                end
                // Capture needs an empty slot and grant a full one, so they never collide.
                if (write_edge[i] && !slot_full[i]) begin
                    slot_full[i] <= 1'b1;
                end else if (out_free && grant_valid && (grant_idx == IDX_W'(i))) begin
                    slot_full[i] <= 1'b0;
                end
            end
            if (out_free) begin
                if (grant_valid) begin
                    fb_pixel <= slot[grant_idx];
                    fb_valid <= 1'b1;
                    rr       <= grant_idx;
                end else begin
                    fb_valid <= 1'b0;
                end
            end
        end
    end

    // NOTE: slot payloads are only meaningful while slot_full is set, so they carry no reset.
    always_ff @(posedge clock) begin
        for (int i = 0; i < N_RAST; i++) begin
            if (write_edge[i] && !slot_full[i]) begin
                slot[i] <= lane_pixel[i];
            end
        end
    end

endmodule
